// File: rtl/qa_drv_rd_sched_pkg.sv
// rtl/qa_drv_rd_sched_pkg.sv - shared types and helpers for the read-request scheduler
package qa_drv_rd_sched_pkg;

   // Default build geometry; instances may override through module parameters.
   localparam int unsigned DEF_N_REQ       = 2;
   localparam int unsigned DEF_N_ENTRIES   = 32;
   localparam int unsigned DEF_N_ADDR_BITS = 56;

   typedef logic [$clog2(DEF_N_REQ)-1:0]     t_REQ_ID;
   typedef logic [$clog2(DEF_N_ENTRIES)-1:0] t_SB_IDX;
   typedef logic [DEF_N_ADDR_BITS-1:0]       t_LINE_ADDR;

   typedef enum logic [1:0] {
      RUN,
      DRAIN,
      DRAINED
   } t_RD_SCHED_STATE;

   // Saturating increment for the statistics counters.
   function automatic logic [31:0] sat_inc32(input logic [31:0] v);
      return (&v) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/qa_drv_rr_arb.sv
// rtl/qa_drv_rr_arb.sv - N-way round-robin grant with registered priority pointer
module qa_drv_rr_arb #(
   parameter  int N_REQ = 2,
   localparam int ID_W  = $clog2(N_REQ)
) (
   input  logic              clk,
   input  logic              resetb,
   input  logic [N_REQ-1:0]  req,
   input  logic              en,
   output logic [N_REQ-1:0]  gnt,
   output logic [ID_W-1:0]   gnt_id
);

   logic [ID_W-1:0] rr_ptr;
   logic [ID_W:0]   sum;
   logic [ID_W-1:0] idx;
   logic            found;

   // Search upward from rr_ptr (mod N_REQ) for the first active request.
   always_comb begin
      gnt    = '0;
      gnt_id = '0;
      found  = 1'b0;
      sum    = '0;
      idx    = '0;
      for (int k = 0; k < N_REQ; k++) begin
         sum = {1'b0, rr_ptr} + (ID_W+1)'(k);
         if (sum >= (ID_W+1)'(N_REQ)) begin
            sum = sum - (ID_W+1)'(N_REQ);
         end
         idx = sum[ID_W-1:0];
         if (en && !found && req[idx]) begin
            gnt[idx] = 1'b1;
            gnt_id   = idx;
            found    = 1'b1;
         end
      end
   end

   // The winner becomes lowest priority: pointer moves to the slot after it.
   always_ff @(posedge clk) begin
      if (!resetb) begin
         rr_ptr <= '0;
      end else if (|gnt) begin
         rr_ptr <= (gnt_id == ID_W'(N_REQ-1)) ? '0 : gnt_id + ID_W'(1);
      end
   end

endmodule

// File: rtl/qa_drv_rd_sched.sv
// rtl/qa_drv_rd_sched.sv - read scheduler sharing one read channel and scoreboard; stats under QA_RD_SCHED_STATS_EN
module qa_drv_rd_sched
   import qa_drv_rd_sched_pkg::*;
#(
   parameter  int N_REQ       = 2,
   parameter  int N_ENTRIES   = 32,
   parameter  int N_ADDR_BITS = 56,
   parameter  int N_DATA_BITS = 512,
   localparam int ID_W        = $clog2(N_REQ),
   localparam int IDX_W       = $clog2(N_ENTRIES),
   localparam int CNT_W       = IDX_W + 1
) (
   input  logic                         clk,
   input  logic                         resetb,
   input  logic [N_REQ-1:0]             req_en,
   input  logic [N_REQ*N_ADDR_BITS-1:0] req_addr,
   output logic [N_REQ-1:0]             req_rdy,
   output logic                         sb_enq_en,
   output logic [ID_W-1:0]              sb_enqMeta,
   input  logic                         sb_notFull,
   input  logic [IDX_W-1:0]             sb_enqIdx,
   output logic                         rd_req_en,
   output logic [N_ADDR_BITS-1:0]       rd_req_addr,
   output logic [IDX_W-1:0]             rd_req_tag,
   input  logic                         rd_req_almostFull,
   input  logic                         sb_notEmpty,
   input  logic [N_DATA_BITS-1:0]       sb_first,
   input  logic [ID_W-1:0]              sb_firstMeta,
   output logic                         sb_deq_en,
   input  logic [N_REQ-1:0]             rsp_rdy,
   output logic [N_REQ-1:0]             rsp_en,
   output logic [N_DATA_BITS-1:0]       rsp_data,
   input  logic                         drain_req,
   output logic                         drained,
   output logic [CNT_W-1:0]             outstanding,
   output logic [N_REQ*32-1:0]          stat_issued,
   output logic [31:0]                  stat_stall
);

   t_RD_SCHED_STATE        state;
   logic                   can_issue;
   logic                   accept;
   logic [N_REQ-1:0]       gnt;
   logic [ID_W-1:0]        gnt_id;
   logic [N_ADDR_BITS-1:0] sel_addr;
   logic                   iss_vld;
   logic [N_ADDR_BITS-1:0] iss_addr;
   logic [IDX_W-1:0]       iss_tag;
   logic [CNT_W-1:0]       outstanding_q;
   logic [CNT_W-1:0]       outstanding_nxt;
   logic                   drained_q;

   // Grants and strobes are held off while resetb is low so that a reset
   // landing mid-burst silences the interface in the same cycle the
   // scoreboard is being cleared.
   assign can_issue = resetb && (state == RUN) && sb_notFull && !rd_req_almostFull;

   qa_drv_rr_arb #(
      .N_REQ (N_REQ)
   ) u_arb (
      .clk    (clk),
      .resetb (resetb),
      .req    (req_en),
      .en     (can_issue),
      .gnt    (gnt),
      .gnt_id (gnt_id)
   );

   assign req_rdy    = gnt;
   assign accept     = |gnt;
   assign sb_enq_en  = accept;
   assign sb_enqMeta = gnt_id;

   // Pick the winning requester's address slice out of the packed bus.
   always_comb begin
      sel_addr = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (gnt[i]) begin
            sel_addr = req_addr[i*N_ADDR_BITS +: N_ADDR_BITS];
         end
      end
   end

   // One-deep issue stage: the accepted address/slot go out the cycle after.
   always_ff @(posedge clk) begin
      if (!resetb) begin
         iss_vld  <= 1'b0;
         iss_addr <= '0;
         iss_tag  <= '0;
      end else begin
         iss_vld <= accept;
         if (accept) begin
            iss_addr <= sel_addr;
            iss_tag  <= sb_enqIdx;
         end
      end
   end

   assign rd_req_en   = iss_vld && resetb;
   assign rd_req_addr = iss_addr;
   assign rd_req_tag  = iss_tag;

   // Steer the in-order head to its owner; a stalled owner blocks the queue.
   always_comb begin
      rsp_en = '0;
      for (int i = 0; i < N_REQ; i++) begin
         rsp_en[i] = resetb && sb_notEmpty && (sb_firstMeta == ID_W'(i)) && rsp_rdy[i];
      end
   end

   assign sb_deq_en = |rsp_en;
   assign rsp_data  = sb_first;

   // Net change of live slots this cycle; simultaneous enq and deq cancel.
   always_comb begin
      outstanding_nxt = outstanding_q;
      if (accept && !sb_deq_en) begin
         outstanding_nxt = outstanding_q + CNT_W'(1);
      end else if (!accept && sb_deq_en) begin
         outstanding_nxt = outstanding_q - CNT_W'(1);
      end
   end

   // Live slot counter.
   always_ff @(posedge clk) begin
      if (!resetb) begin
         outstanding_q <= '0;
      end else begin
         outstanding_q <= outstanding_nxt;
      end
   end

   assign outstanding = outstanding_q;

   // Drain FSM; idle is judged on next-cycle counts so drained rises the
   // cycle right after the last dequeue.
   always_ff @(posedge clk) begin
      if (!resetb) begin
         state     <= RUN;
         drained_q <= 1'b0;
      end else begin
         case (state)
            RUN: begin
               if (drain_req) begin
                  if ((outstanding_nxt == '0) && !accept) begin
                     state     <= DRAINED;
                     drained_q <= 1'b1;
                  end else begin
                     state <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               if (outstanding_nxt == '0) begin
                  state     <= DRAINED;
                  drained_q <= 1'b1;
               end
            end
            DRAINED: begin
               if (!drain_req) begin
                  state     <= RUN;
                  drained_q <= 1'b0;
               end
            end
            default: begin
               state     <= RUN;
               drained_q <= 1'b0;
            end
         endcase
      end
   end

   assign drained = drained_q && resetb;

   // A dequeue with nothing allocated means the scoreboard and this block disagree.
   a_no_underflow: assert property (@(posedge clk) disable iff (!resetb)
      !(sb_deq_en && !accept && (outstanding_q == '0)));

`ifdef QA_RD_SCHED_STATS_EN
   logic [N_REQ-1:0][31:0] stat_issued_q;
   logic [31:0]            stat_stall_q;

   // Saturating per-requester issue counts and blocked-request cycles.
   always_ff @(posedge clk) begin
      if (!resetb) begin
         stat_issued_q <= '0;
         stat_stall_q  <= '0;
      end else begin
         for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
               stat_issued_q[i] <= sat_inc32(stat_issued_q[i]);
            end
         end
         if (|req_en && !can_issue) begin
            stat_stall_q <= sat_inc32(stat_stall_q);
         end
      end
   end

   assign stat_issued = stat_issued_q;
   assign stat_stall  = stat_stall_q;
`else
   assign stat_issued = '0;
   assign stat_stall  = '0;
`endif

endmodule

// File: tb/tb_qa_drv_rd_sched.sv
// tb/tb_qa_drv_rd_sched.sv - self-checking bench for qa_drv_rd_sched
module tb_qa_drv_rd_sched;

   localparam int N_REQ = 2;
   localparam int AW    = 56;
   localparam int DW    = 512;

   logic              clk = 1'b0;
   logic              resetb;
   logic [1:0]        req_en;
   logic [2*AW-1:0]   req_addr;
   logic [1:0]        req_rdy;
   logic              sb_enq_en;
   logic              sb_enqMeta;
   logic              sb_notFull;
   logic [4:0]        sb_enqIdx;
   logic              rd_req_en;
   logic [AW-1:0]     rd_req_addr;
   logic [4:0]        rd_req_tag;
   logic              rd_req_almostFull;
   logic              sb_notEmpty;
   logic [DW-1:0]     sb_first;
   logic              sb_firstMeta;
   logic              sb_deq_en;
   logic [1:0]        rsp_rdy;
   logic [1:0]        rsp_en;
   logic [DW-1:0]     rsp_data;
   logic              drain_req;
   logic              drained;
   logic [5:0]        outstanding;
   logic [63:0]       stat_issued;
   logic [31:0]       stat_stall;

   int errors = 0;
   int checks = 0;

   // Behavioural model state: mode 0=accepting, 1=draining, 2=drained.
   typedef struct {
      logic [AW-1:0] addr;
      logic [4:0]    tag;
   } iss_t;

   int          m_mode;
   int          m_ptr;
   int          m_out;
   iss_t        m_q[$];
   logic [31:0] m_stall;
   logic [31:0] m_iss [N_REQ];
   logic [4:0]  a_ptr;

   assign sb_enqIdx = a_ptr;

   qa_drv_rd_sched u_dut (
      .clk               (clk),
      .resetb            (resetb),
      .req_en            (req_en),
      .req_addr          (req_addr),
      .req_rdy           (req_rdy),
      .sb_enq_en         (sb_enq_en),
      .sb_enqMeta        (sb_enqMeta),
      .sb_notFull        (sb_notFull),
      .sb_enqIdx         (sb_enqIdx),
      .rd_req_en         (rd_req_en),
      .rd_req_addr       (rd_req_addr),
      .rd_req_tag        (rd_req_tag),
      .rd_req_almostFull (rd_req_almostFull),
      .sb_notEmpty       (sb_notEmpty),
      .sb_first          (sb_first),
      .sb_firstMeta      (sb_firstMeta),
      .sb_deq_en         (sb_deq_en),
      .rsp_rdy           (rsp_rdy),
      .rsp_en            (rsp_en),
      .rsp_data          (rsp_data),
      .drain_req         (drain_req),
      .drained           (drained),
      .outstanding       (outstanding),
      .stat_issued       (stat_issued),
      .stat_stall        (stat_stall)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_w(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // First active requester at or after ptr, wrapping; -1 if none.
   function automatic int pick(input int ptr, input logic [1:0] req);
      for (int k = 0; k < N_REQ; k++) begin
         if (req[(ptr + k) % N_REQ]) return (ptr + k) % N_REQ;
      end
      return -1;
   endfunction

   function automatic int m_grant();
      if (resetb !== 1'b1 || m_mode != 0 || !sb_notFull || rd_req_almostFull) return -1;
      return pick(m_ptr, req_en);
   endfunction

   function automatic logic [1:0] m_rsp();
      if (resetb !== 1'b1 || !sb_notEmpty) return 2'b00;
      if (!rsp_rdy[sb_firstMeta]) return 2'b00;
      return sb_firstMeta ? 2'b10 : 2'b01;
   endfunction

   // Compare every DUT output against the model between clock edges.
   always @(negedge clk) begin
      int         g;
      logic [1:0] er;
      logic       rd_exp;
      g      = m_grant();
      er     = m_rsp();
      rd_exp = (resetb === 1'b1) && (m_q.size() > 0);
      chk("m_req_rdy", 64'(req_rdy), (g >= 0) ? 64'(1 << g) : 64'd0);
      chk("m_sb_enq_en", 64'(sb_enq_en), (g >= 0) ? 64'd1 : 64'd0);
      if (g >= 0) chk("m_sb_enqMeta", 64'(sb_enqMeta), 64'(g));
      chk("m_rd_req_en", 64'(rd_req_en), 64'(rd_exp));
      if (rd_exp) begin
         chk("m_rd_req_addr", 64'(rd_req_addr), 64'(m_q[0].addr));
         chk("m_rd_req_tag", 64'(rd_req_tag), 64'(m_q[0].tag));
      end
      chk("m_rsp_en", 64'(rsp_en), 64'(er));
      chk("m_sb_deq_en", 64'(sb_deq_en), 64'(|er));
      if (|er) chk_w("m_rsp_data", rsp_data, sb_first);
      chk("m_drained", 64'(drained), 64'((resetb === 1'b1) && (m_mode == 2)));
      chk("m_outstanding", 64'(outstanding), 64'(m_out));
`ifdef QA_RD_SCHED_STATS_EN
      chk("m_stat_stall", 64'(stat_stall), 64'(m_stall));
      for (int i = 0; i < N_REQ; i++) chk("m_stat_issued", 64'(stat_issued[i*32 +: 32]), 64'(m_iss[i]));
`else
      chk("m_stat_stall", 64'(stat_stall), 64'd0);
      chk("m_stat_issued", stat_issued, 64'd0);
`endif
   end

   // Advance the model on each rising edge from the inputs seen there.
   always @(posedge clk) begin
      int         g;
      int         nout;
      logic [1:0] er;
      if (resetb !== 1'b1) begin
         m_mode  = 0;
         m_ptr   = 0;
         m_out   = 0;
         m_q.delete();
         m_stall = '0;
         for (int i = 0; i < N_REQ; i++) m_iss[i] = '0;
         a_ptr  <= '0;
      end else begin
         g  = m_grant();
         er = m_rsp();
         if (m_q.size() > 0) void'(m_q.pop_front());
         if ((|req_en) && !(m_mode == 0 && sb_notFull && !rd_req_almostFull) && (m_stall != 32'hFFFF_FFFF))
            m_stall = m_stall + 32'd1;
         nout = m_out - ((|er) ? 1 : 0);
         if (g >= 0) begin
            m_q.push_back('{req_addr[g*AW +: AW], sb_enqIdx});
            m_ptr = (g + 1) % N_REQ;
            a_ptr <= a_ptr + 5'd1;
            if (m_iss[g] != 32'hFFFF_FFFF) m_iss[g] = m_iss[g] + 32'd1;
            nout = nout + 1;
         end
         case (m_mode)
            0: if (drain_req) m_mode = (nout == 0 && g < 0) ? 2 : 1;
            1: if (nout == 0) m_mode = 2;
            default: if (!drain_req) m_mode = 0;
         endcase
         m_out = nout;
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      req_en            = 2'b00;
      drain_req         = 1'b0;
      sb_notEmpty       = 1'b0;
      rsp_rdy           = 2'b00;
      sb_notFull        = 1'b1;
      rd_req_almostFull = 1'b0;
   endtask

   task automatic do_reset();
      resetb = 1'b0;
      cyc();
      resetb = 1'b1;
   endtask

   task automatic set_addr(input int i, input logic [AW-1:0] a);
      req_addr[i*AW +: AW] = a;
   endtask

   // Directed sequence with hand-computed literal expectations.
   initial begin
      resetb       = 1'b0;
      idle();
      req_addr     = '0;
      sb_first     = '0;
      sb_firstMeta = 1'b0;
      repeat (3) cyc();
      @(negedge clk);
      chk("reset_outstanding", 64'(outstanding), 64'd0);
      chk("reset_req_rdy", 64'(req_rdy), 64'd0);
      chk("reset_drained", 64'(drained), 64'd0);
      cyc();
      resetb = 1'b1;

      // single request from requester 0
      set_addr(0, 56'h100);
      req_en = 2'b01;
      @(negedge clk);
      chk("t1_req_rdy", 64'(req_rdy), 64'h1);
      chk("t1_enq", 64'(sb_enq_en), 64'h1);
      chk("t1_meta", 64'(sb_enqMeta), 64'h0);
      cyc();
      req_en = 2'b00;
      @(negedge clk);
      chk("t1_rd_en", 64'(rd_req_en), 64'h1);
      chk("t1_rd_addr", 64'(rd_req_addr), 64'h100);
      chk("t1_rd_tag", 64'(rd_req_tag), 64'h0);
      chk("t1_outstanding", 64'(outstanding), 64'h1);
      cyc();

      // both requesting back-to-back from a clean reset
      do_reset();
      set_addr(0, 56'h200);
      set_addr(1, 56'h300);
      req_en = 2'b11;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         chk("t2_grant", 64'(req_rdy), (k % 2 == 0) ? 64'h1 : 64'h2);
         if (k > 0) chk("t2_tag", 64'(rd_req_tag), 64'(k - 1));
         cyc();
      end
      req_en = 2'b00;
      @(negedge clk);
      chk("t2_last_tag", 64'(rd_req_tag), 64'h5);
      chk("t2_outstanding", 64'(outstanding), 64'h6);
      cyc();

      // scoreboard full, then channel back-pressure
      req_en     = 2'b11;
      sb_notFull = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("t3_full_rdy", 64'(req_rdy), 64'h0);
         chk("t3_full_rd_en", 64'(rd_req_en), 64'h0);
         cyc();
      end
      sb_notFull = 1'b1;
      req_en     = 2'b00;
`ifdef QA_RD_SCHED_STATS_EN
      @(negedge clk);
      chk("t3_stat_stall", 64'(stat_stall), 64'h4);
`endif
      cyc();
      req_en            = 2'b10;
      rd_req_almostFull = 1'b1;
      @(negedge clk);
      chk("t3_af_rdy", 64'(req_rdy), 64'h0);
      cyc();
      rd_req_almostFull = 1'b0;
      @(negedge clk);
      chk("t3_af_release", 64'(req_rdy), 64'h2);
      cyc();
      req_en = 2'b00;
      cyc();

      // head-of-line blocking, then deliveries down to 3 outstanding
      sb_notEmpty  = 1'b1;
      sb_firstMeta = 1'b1;
      sb_first     = {16{32'hDEAD_0001}};
      rsp_rdy      = 2'b01;
      @(negedge clk);
      chk("t4_block_rsp", 64'(rsp_en), 64'h0);
      chk("t4_block_deq", 64'(sb_deq_en), 64'h0);
      cyc();
      rsp_rdy = 2'b11;
      @(negedge clk);
      chk("t4_rsp_en", 64'(rsp_en), 64'h2);
      chk("t4_deq", 64'(sb_deq_en), 64'h1);
      chk_w("t4_rsp_data", rsp_data, {16{32'hDEAD_0001}});
      cyc();
      sb_firstMeta = 1'b0;
      sb_first     = {16{32'hBEEF_0002}};
      @(negedge clk);
      chk("t4_rsp_en0", 64'(rsp_en), 64'h1);
      cyc();
      sb_firstMeta = 1'b1;
      cyc();
      sb_firstMeta = 1'b0;
      cyc();
      sb_notEmpty = 1'b0;
      @(negedge clk);
      chk("t4_outstanding", 64'(outstanding), 64'h3);

      // drain with 3 outstanding
      drain_req = 1'b1;
      cyc();
      req_en      = 2'b11;
      sb_notEmpty = 1'b1;
      for (int j = 0; j < 3; j++) begin
         sb_firstMeta = (j % 2 == 1);
         @(negedge clk);
         chk("t5_no_grant", 64'(req_rdy), 64'h0);
         chk("t5_not_drained", 64'(drained), 64'h0);
         chk("t5_deq", 64'(sb_deq_en), 64'h1);
         cyc();
      end
      sb_notEmpty = 1'b0;
      @(negedge clk);
      chk("t5_drained", 64'(drained), 64'h1);
      chk("t5_outstanding", 64'(outstanding), 64'h0);
      cyc();
      drain_req = 1'b0;
      @(negedge clk);
      chk("t5_still_drained", 64'(drained), 64'h1);
      chk("t5_drained_rdy", 64'(req_rdy), 64'h0);
      cyc();
      @(negedge clk);
      chk("t5_resume_rdy", 64'(req_rdy), 64'h1);
      chk("t5_resume_drained", 64'(drained), 64'h0);
      cyc();

      // simultaneous accept and dequeue, reset mid-burst
      req_en       = 2'b01;
      sb_notEmpty  = 1'b1;
      sb_firstMeta = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("t6_outstanding", 64'(outstanding), 64'h1);
         chk("t6_enq", 64'(sb_enq_en), 64'h1);
         chk("t6_deq", 64'(sb_deq_en), 64'h1);
         cyc();
      end
      resetb = 1'b0;
      @(negedge clk);
      chk("t6_rst_rdy", 64'(req_rdy), 64'h0);
      chk("t6_rst_enq", 64'(sb_enq_en), 64'h0);
      chk("t6_rst_rd_en", 64'(rd_req_en), 64'h0);
      chk("t6_rst_rsp", 64'(rsp_en), 64'h0);
      chk("t6_rst_deq", 64'(sb_deq_en), 64'h0);
      chk("t6_rst_drained", 64'(drained), 64'h0);
      cyc();
      idle();
      @(negedge clk);
      chk("t6_rst_outstanding", 64'(outstanding), 64'h0);
      chk("t6_rst_rd_en2", 64'(rd_req_en), 64'h0);
      cyc();
      resetb = 1'b1;
      cyc();

      // drain request with nothing outstanding
      drain_req = 1'b1;
      @(negedge clk);
      chk("t7_pre_drained", 64'(drained), 64'h0);
      cyc();
      @(negedge clk);
      chk("t7_drained", 64'(drained), 64'h1);
      cyc();
      drain_req = 1'b0;
      cyc();
      cyc();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
